// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: load-type codes, the memory data
// register FSM states and the default capture-state encoding.
package mips_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4,
    LWL = 3'd5,
    LWR = 3'd6
  } load_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HOLD    = 2'd2
  } dr_fsm_e;

  localparam int CAPTURE_STATE_DEFAULT = 2;

endpackage

// File: rtl/mem_data_register_load_align.sv
// load_align: combinational byte/half extraction, extension and
// LWL/LWR merge. In: word, load_type, offset, rt. Out: result.
module load_align
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]         word,
  input  logic [2:0]                    load_type,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  input  logic [DATA_WIDTH-1:0]         rt,
  output logic [DATA_WIDTH-1:0]         result
);

  localparam int OW = $clog2(DATA_WIDTH/8);

  logic [OW-1:0]         hoff;
  logic [7:0]            b;
  logic [15:0]           h;
  logic [DATA_WIDTH-1:0] lwl;
  logic [DATA_WIDTH-1:0] lwr;

  // Halfword loads ignore the low offset bit.
  assign hoff = {offset[OW-1:1], 1'b0};
  assign b = 8'(word >> {offset, 3'b000});
  assign h = 16'(word >> {hoff, 3'b000});

  if (DATA_WIDTH == 32) begin : g_merge
    logic [1:0] inv;
    assign inv = 2'd3 - offset;
    assign lwl = (word << {inv, 3'b000})
               | (rt & ~(32'hFFFF_FFFF << {inv, 3'b000}));
    assign lwr = (word >> {offset, 3'b000})
               | (rt & ~(32'hFFFF_FFFF >> {offset, 3'b000}));
  end else begin : g_nomerge
    assign lwl = word;
    assign lwr = word;
  end

  always_comb begin
    result = word;
    unique case (load_type_e'(load_type))
      LB:  result = {{(DATA_WIDTH-8){b[7]}}, b};
      LBU: result = {{(DATA_WIDTH-8){1'b0}}, b};
      LH:  result = {{(DATA_WIDTH-16){h[15]}}, h};
      LHU: result = {{(DATA_WIDTH-16){1'b0}}, h};
      LWL: result = lwl;
      LWR: result = lwr;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_data_register.sv
// Memory data register: captures bus read data on handshake, stalls
// while waitrequest is high, and exposes a load-aligned result.
// Ports: clk, reset (sync, low), state, read_issue, waitrequest,
// dr_writedata, load_type, byte_offset, rt_data -> dr_readdata,
// load_result, dr_valid, stall.
module mem_data_register
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STATE_WIDTH = 3,
  parameter logic [STATE_WIDTH-1:0] CAPTURE_STATE =
    STATE_WIDTH'(CAPTURE_STATE_DEFAULT)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [STATE_WIDTH-1:0]          state,
  input  logic                            read_issue,
  input  logic                            waitrequest,
  input  logic [DATA_WIDTH-1:0]           dr_writedata,
  input  logic [2:0]                      load_type,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] byte_offset,
  input  logic [DATA_WIDTH-1:0]           rt_data,
  output logic [DATA_WIDTH-1:0]           dr_readdata,
  output logic [DATA_WIDTH-1:0]           load_result,
  output logic                            dr_valid,
  output logic                            stall
);

  localparam int OW = $clog2(DATA_WIDTH/8);

  dr_fsm_e       fsm;
  logic [2:0]    cap_type;
  logic [OW-1:0] cap_off;
  logic          issue;

  assign issue = (state == CAPTURE_STATE) && read_issue;

  assign stall = waitrequest &&
                 ((fsm == PENDING) || (issue && fsm != PENDING));

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm         <= IDLE;
      dr_readdata <= '0;
      cap_type    <= LW;
      cap_off     <= '0;
      dr_valid    <= 1'b0;
    end else begin
      unique case (fsm)
        PENDING: begin
          // Issue inputs are ignored until the bus answers.
          if (!waitrequest) begin
            dr_readdata <= dr_writedata;
            dr_valid    <= 1'b1;
            fsm         <= HOLD;
          end
        end
        default: begin
          if (issue) begin
            cap_type <= load_type;
            cap_off  <= byte_offset;
            if (!waitrequest) begin
              dr_readdata <= dr_writedata;
              dr_valid    <= 1'b1;
              fsm         <= HOLD;
            end else begin
              dr_valid <= 1'b0;
              fsm      <= PENDING;
            end
          end
        end
      endcase
    end
  end

  load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .word     (dr_readdata),
    .load_type(cap_type),
    .offset   (cap_off),
    .rt       (rt_data),
    .result   (load_result)
  );

endmodule

// File: tb/tb_mem_data_register.sv
// Bench for mem_data_register: directed literal cases plus random
// traffic compared each cycle against a byte-level reference model.
module tb_mem_data_register;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  state;
  logic        read_issue;
  logic        waitrequest;
  logic [31:0] dr_writedata;
  logic [2:0]  load_type;
  logic [1:0]  byte_offset;
  logic [31:0] rt_data;
  logic [31:0] dr_readdata;
  logic [31:0] load_result;
  logic        dr_valid;
  logic        stall;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  mem_data_register #(
    .DATA_WIDTH(32),
    .STATE_WIDTH(3),
    .CAPTURE_STATE(3'd2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .state(state),
    .read_issue(read_issue),
    .waitrequest(waitrequest),
    .dr_writedata(dr_writedata),
    .load_type(load_type),
    .byte_offset(byte_offset),
    .rt_data(rt_data),
    .dr_readdata(dr_readdata),
    .load_result(load_result),
    .dr_valid(dr_valid),
    .stall(stall)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference load semantics, built byte by byte.
  function automatic logic [31:0] ref_load(
    logic [31:0] w, logic [2:0] t, logic [1:0] o, logic [31:0] rt);
    logic [7:0] wb[4];
    logic [7:0] rb[4];
    logic [7:0] rs[4];
    logic [15:0] hw;
    int s;
    for (int i = 0; i < 4; i++) begin
      wb[i] = w[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    s = int'(o) & 2;
    hw = {wb[s+1], wb[s]};
    case (t)
      3'd1: return {{24{wb[o][7]}}, wb[o]};
      3'd2: return {24'h0, wb[o]};
      3'd3: return {{16{hw[15]}}, hw};
      3'd4: return {16'h0, hw};
      3'd5: begin
        for (int i = 0; i < 4; i++)
          rs[i] = (i >= 3 - int'(o)) ? wb[i-(3-int'(o))] : rb[i];
        return {rs[3], rs[2], rs[1], rs[0]};
      end
      3'd6: begin
        for (int i = 0; i < 4; i++)
          rs[i] = (i + int'(o) <= 3) ? wb[i+int'(o)] : rb[i];
        return {rs[3], rs[2], rs[1], rs[0]};
      end
      default: return w;
    endcase
  endfunction

  bit          m_pend;
  bit          m_valid;
  logic [31:0] m_word;
  logic [2:0]  m_type;
  logic [1:0]  m_off;

  always @(posedge clk) begin
    if (!reset) begin
      m_pend = 0; m_valid = 0;
      m_word = 0; m_type = 0; m_off = 0;
    end else if (m_pend) begin
      if (!waitrequest) begin
        m_word = dr_writedata; m_valid = 1; m_pend = 0;
      end
    end else if (state == 3'd2 && read_issue) begin
      m_type = load_type; m_off = byte_offset;
      if (!waitrequest) begin
        m_word = dr_writedata; m_valid = 1;
      end else begin
        m_pend = 1; m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      #3;
      chk("rd", dr_readdata, m_word);
      chk("valid", 32'(dr_valid), 32'(m_valid));
      chk("stall", 32'(stall), 32'(waitrequest &&
          (m_pend || (state == 3'd2 && read_issue))));
      chk("result", load_result,
          ref_load(m_word, m_type, m_off, rt_data));
    end
  end

  task automatic idle();
    state = 0; read_issue = 0; waitrequest = 0;
    dr_writedata = 0; load_type = 0; byte_offset = 0;
  endtask

  task automatic do_load(string nm, logic [31:0] w, logic [2:0] t,
                         logic [1:0] o, logic [31:0] rt,
                         logic [31:0] exp);
    state = 2; read_issue = 1; waitrequest = 0;
    dr_writedata = w; load_type = t; byte_offset = o; rt_data = rt;
    @(negedge clk);
    read_issue = 0;
    #1 chk(nm, load_result, exp);
  endtask

  int stalls;

  initial begin
    reset = 0; rt_data = 0;
    idle();
    @(negedge clk);
    checking = 1;
    #1;
    chk("rst_rd", dr_readdata, 0);
    chk("rst_valid", 32'(dr_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_result", load_result, 0);
    reset = 1;

    do_load("lw0", 32'hDEADBEEF, LW, 0, 0, 32'hDEADBEEF);
    chk("lw0_rd", dr_readdata, 32'hDEADBEEF);
    chk("lw0_valid", 32'(dr_valid), 1);

    stalls = 0;
    state = 2; read_issue = 1; waitrequest = 1;
    dr_writedata = 32'hCAFE0000; load_type = LW;
    for (int i = 0; i < 3; i++) begin
      #1 if (stall) stalls++;
      @(negedge clk);
      state = 0; read_issue = 0;
      dr_writedata = 32'hBAD0BAD0 + i;
    end
    waitrequest = 0; dr_writedata = 32'h12345678;
    #1 if (stall) stalls++;
    @(negedge clk);
    #1;
    chk("ws_stalls", stalls, 3);
    chk("ws_rd", dr_readdata, 32'h12345678);
    chk("ws_valid", 32'(dr_valid), 1);

    state = 1; read_issue = 1; waitrequest = 0;
    dr_writedata = 32'h55555555;
    @(negedge clk);
    #1 chk("nostate_rd", dr_readdata, 32'h12345678);
    state = 2; waitrequest = 1;
    @(negedge clk);
    read_issue = 0;
    #1 chk("pend_rd", dr_readdata, 32'h12345678);
    chk("pend_valid", 32'(dr_valid), 0);
    waitrequest = 0;
    @(negedge clk);

    do_load("lh2", 32'h80017F00, LH, 2, 0, 32'hFFFF8001);
    do_load("lbu1", 32'h123456F0, LBU, 1, 0, 32'h00000056);
    do_load("lb0", 32'h000000F0, LB, 0, 0, 32'hFFFFFFF0);
    do_load("lwl1", 32'hAABBCCDD, LWL, 1, 32'h11223344,
            32'hCCDD3344);
    do_load("lwr1", 32'hAABBCCDD, LWR, 1, 32'h11223344,
            32'h11AABBCC);
    rt_data = 32'h00FF00FF;
    #1 chk("lwr_rt", load_result, 32'h00AABBCC);

    state = 2; read_issue = 1; waitrequest = 1; load_type = LW;
    @(negedge clk);
    read_issue = 0; reset = 0;
    @(negedge clk);
    reset = 1; waitrequest = 0; dr_writedata = 32'hFFFFFFFF;
    @(negedge clk);
    #1;
    chk("abort_rd", dr_readdata, 0);
    chk("abort_valid", 32'(dr_valid), 0);
    chk("abort_stall", 32'(stall), 0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      state = ($urandom_range(0, 3) != 0) ? 3'd2
            : 3'($urandom_range(0, 7));
      read_issue = 1'($urandom_range(0, 1));
      waitrequest = ($urandom_range(0, 9) < 4);
      dr_writedata = $urandom;
      load_type = 3'($urandom_range(0, 7));
      byte_offset = 2'($urandom_range(0, 3));
      rt_data = $urandom;
    end
    @(negedge clk);
    idle();
    reset = 1;
    repeat (2) @(negedge clk);
    #5;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
